peripheral_dma: RTL and testbench
=================================

// Module: peripheral_dma
// PURPOSE
//  Memory-to-memory word copy engine; the bus initiator counterpart to the SoC's responders (bram, peripherals).
//  CPU programs it through a chip-selected register slot (cs/addr/rd/wr/d_in/d_out, like other peripherals).
//  It then requests the memory bus and drives mem_* style reads/writes itself until LEN words are copied.
// PARAMETERS
//  ADDR_W  32  width of m_addr and SRC/DST registers
//  LEN_W   16  width of LEN register (max 2^LEN_W-1 words per transfer)
// PORTS
//  clk       in   1       system clock
//  resetn    in   1       asynchronous active-low reset
//  d_in      in   32      CPU write data
//  cs        in   1       chip select from SoC address decoder
//  addr      in   5       register offset (byte address, word aligned)
//  rd        in   1       CPU read strobe
//  wr        in   1       CPU write strobe
//  d_out     out  32      CPU read data
//  m_req     out  1       bus request to arbiter
//  m_gnt     in   1       bus grant; master port valid only while m_gnt=1
//  m_addr    out  ADDR_W  initiator address (word aligned, [1:0]=0)
//  m_rstrb   out  1       one-cycle read strobe
//  m_rdata   in   32      read data, valid the cycle after m_rstrb when m_rbusy=0
//  m_wdata   out  32      write data
//  m_wmask   out  4       byte write mask (4'hF on write cycle, else 0)
//  m_rbusy   in   1       responder read stall
//  m_wbusy   in   1       responder write stall
//  irq       out  1       done interrupt (only with DMA_IRQ_EN)
// BEHAVIOUR
//  Regs: 0x00 SRC, 0x04 DST, 0x08 LEN[LEN_W-1:0], 0x0C CTRL (wr bit0=START), 0x10 STATUS {30'b0,done,busy}.
//  CPU writes are one cycle (cs&wr); d_out registered, valid the cycle after cs&rd; unmapped offsets read 0.
//  Reset: all regs 0, d_out=0, m_req=0, m_rstrb=0, m_wmask=0, m_addr=0, m_wdata=0, busy=0, done=0, irq=0.
//  FSM: IDLE -> REQ on START (LEN!=0); START with LEN==0 sets done next cycle, stays IDLE.
//   REQ: m_req=1; wait m_gnt -> RD.
//   RD: m_addr=SRC_cur, m_rstrb=1 for exactly one cycle -> RWAIT.
//   RWAIT: hold while m_rbusy; when m_rbusy=0 latch m_rdata into buffer -> WR.
//   WR: m_addr=DST_cur, m_wdata=buffer, m_wmask=4'hF; hold while m_wbusy -> NEXT.
//   NEXT: SRC_cur+=4, DST_cur+=4, cnt-=1; cnt==0 -> DONE else RD.
//   DONE: m_req=0, busy=0, done=1 -> IDLE.
//  m_req held 1 from REQ through NEXT; minimum 3 cycles/word (RD,RWAIT,WR) + NEXT = 4.
//  busy=1 from the cycle after START until DONE; done cleared by next START or by reading STATUS.
//  While busy: writes to SRC/DST/LEN and START are ignored; STATUS readable.
//  m_gnt dropped mid-transfer: FSM freezes (no strobes/masks asserted) and resumes same step on regrant.
//  Address wrap: SRC_cur/DST_cur wrap modulo 2^ADDR_W, no error. Low two address bits forced to 0.
//  Simultaneous STATUS read and DONE: read returns done=1, clear-on-read does not lose the event.
//  resetn assertion mid-transfer: immediate abort, all outputs to reset values, no partial write completes.
// CONFIGURATION
//  DMA_IRQ_EN defined: irq output exists; irq=1 from DONE until STATUS read or next START.
//  DMA_IRQ_EN undefined: no irq port; completion only by polling STATUS.done.
// STRUCTURE
//  dma_pkg (include): register offsets, FSM state encodings, STATUS bit positions.
//  One sub-module dma_regfile: CPU-side register decode, readback mux, START pulse; FSM in top.
// TESTING
//  SRC=0x100,DST=0x200,LEN=4, gnt tied 1, zero-wait RAM -> 4 words copied in order, done after 16 cycles of busy.
//  LEN=0, START -> no m_req, no m_rstrb/m_wmask, STATUS=0x2 next read.
//  m_rbusy=1 for 3 cycles on word 2, m_wbusy=1 for 2 cycles on word 3 -> data intact, strobe not re-issued.
//  m_gnt dropped 5 cycles during RWAIT of word 1 -> no bus activity while low, copy completes correctly.
//  While busy write SRC=0xDEAD and START -> ignored; destination contents match original SRC.
//  resetn low during WR of word 2 -> m_wmask=0 same cycle, STATUS=0 after release; with DMA_IRQ_EN irq pulses once per transfer.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the peripheral DMA copy engine: register map,
// sequencer states and STATUS bit layout.
package dma_pkg;

    localparam logic [4:0] REG_SRC    = 5'h00;
    localparam logic [4:0] REG_DST    = 5'h04;
    localparam logic [4:0] REG_LEN    = 5'h08;
    localparam logic [4:0] REG_CTRL   = 5'h0C;
    localparam logic [4:0] REG_STATUS = 5'h10;

    localparam int CTRL_START_BIT = 0;
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RD    = 3'd2,
        ST_RWAIT = 3'd3,
        ST_WR    = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } dma_state_e;

    function automatic logic [31:0] status_word(input logic done, input logic busy);
        logic [31:0] w;
        w                = 32'h0000_0000;
        w[STAT_DONE_BIT] = done;
        w[STAT_BUSY_BIT] = busy;
        return w;
    endfunction

endpackage

// File: rtl/dma_regfile.sv
// CPU-side register slot of the DMA engine: write decode, readback, START pulse
// and the sticky done flag (exported only when DMA_IRQ_EN is defined).
module dma_regfile
    import dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       d_in,
    input  logic              cs,
    input  logic [4:0]        addr,
    input  logic              rd,
    input  logic              wr,
    input  logic              idle,
    input  logic              busy,
    input  logic              done_evt,
    output logic [31:0]       d_out,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic [LEN_W-1:0]  len,
    output logic              start
`ifdef DMA_IRQ_EN
    ,
    output logic              done
`endif
);

    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  len_r;
    logic [31:0]       d_out_r;
    logic              done_r;
    logic              wr_en_s;
    logic              rd_en_s;
    logic              status_rd_s;
    logic              start_s;

    // Strobe decode; configuration is frozen while a copy is in flight
    always_comb begin
        wr_en_s     = cs & wr & idle;
        rd_en_s     = cs & rd;
        status_rd_s = rd_en_s & (addr == REG_STATUS);
        start_s     = wr_en_s & (addr == REG_CTRL) & d_in[CTRL_START_BIT];
    end

    // Configuration registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            src_r <= {ADDR_W{1'b0}};
            dst_r <= {ADDR_W{1'b0}};
            len_r <= {LEN_W{1'b0}};
        end else if (wr_en_s) begin
            case (addr)
                REG_SRC: src_r <= d_in[ADDR_W-1:0];
                REG_DST: dst_r <= d_in[ADDR_W-1:0];
                REG_LEN: len_r <= d_in[LEN_W-1:0];
                default: ;
            endcase
        end
    end

    // Sticky done: a completion in the same cycle as a clearing read still lands
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done_r <= 1'b0;
        end else if (done_evt) begin
            done_r <= 1'b1;
        end else if (status_rd_s | start_s) begin
            done_r <= 1'b0;
        end
    end

    // Registered readback, valid the cycle after the read strobe
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_out_r <= 32'h0000_0000;
        end else if (rd_en_s) begin
            case (addr)
                REG_SRC:    d_out_r <= 32'(src_r);
                REG_DST:    d_out_r <= 32'(dst_r);
                REG_LEN:    d_out_r <= 32'(len_r);
                REG_STATUS: d_out_r <= status_word(done_r | done_evt, busy);
                default:    d_out_r <= 32'h0000_0000;
            endcase
        end
    end

    assign d_out = d_out_r;
    assign src   = src_r;
    assign dst   = dst_r;
    assign len   = len_r;
    assign start = start_s;
`ifdef DMA_IRQ_EN
    assign done  = done_r;
`endif

endmodule

// File: rtl/peripheral_dma.sv
// Memory-to-memory word copy engine acting as a bus initiator.
// Define DMA_IRQ_EN to get the irq completion output.
module peripheral_dma
    import dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       d_in,
    input  logic              cs,
    input  logic [4:0]        addr,
    input  logic              rd,
    input  logic              wr,
    output logic [31:0]       d_out,
    output logic              m_req,
    input  logic              m_gnt,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_rstrb,
    input  logic [31:0]       m_rdata,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wmask,
    input  logic              m_rbusy,
    input  logic              m_wbusy
`ifdef DMA_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam logic [ADDR_W-1:0] WORD_STEP = {{(ADDR_W-3){1'b0}}, 3'd4};
    localparam logic [LEN_W-1:0]  ONE_WORD  = {{(LEN_W-1){1'b0}}, 1'b1};

    dma_state_e        state_r;
    logic [ADDR_W-1:0] src_cur_r;
    logic [ADDR_W-1:0] dst_cur_r;
    logic [LEN_W-1:0]  cnt_r;
    logic              busy_r;
    logic              req_r;
    logic [ADDR_W-1:0] addr_r;
    logic              rstrb_r;
    logic [31:0]       wdata_r;
    logic [3:0]        wmask_r;

    logic [ADDR_W-1:0] src_s;
    logic [ADDR_W-1:0] dst_s;
    logic [LEN_W-1:0]  len_s;
    logic              start_s;
    logic              idle_s;
    logic              done_evt_s;

    dma_regfile #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_regfile (
        .clk      (clk),
        .resetn   (resetn),
        .d_in     (d_in),
        .cs       (cs),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .idle     (idle_s),
        .busy     (busy_r),
        .done_evt (done_evt_s),
        .d_out    (d_out),
        .src      (src_s),
        .dst      (dst_s),
        .len      (len_s),
        .start    (start_s)
`ifdef DMA_IRQ_EN
        ,
        .done     (irq)
`endif
    );

    // Completion event: zero-length start, or the last word retiring
    always_comb begin
        idle_s = (state_r == ST_IDLE);
        if (idle_s && start_s && (len_s == {LEN_W{1'b0}})) begin
            done_evt_s = 1'b1;
        end else if ((state_r == ST_NEXT) && m_gnt && (cnt_r == ONE_WORD)) begin
            done_evt_s = 1'b1;
        end else begin
            done_evt_s = 1'b0;
        end
    end

    // Copy sequencer; every step holds in place while the grant is withdrawn
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            src_cur_r <= {ADDR_W{1'b0}};
            dst_cur_r <= {ADDR_W{1'b0}};
            cnt_r     <= {LEN_W{1'b0}};
            busy_r    <= 1'b0;
            req_r     <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            rstrb_r   <= 1'b0;
            wdata_r   <= 32'h0000_0000;
            wmask_r   <= 4'h0;
        end else begin
            case (state_r)
                ST_IDLE: if (start_s && (len_s != {LEN_W{1'b0}})) begin
                    src_cur_r <= {src_s[ADDR_W-1:2], 2'b00};
                    dst_cur_r <= {dst_s[ADDR_W-1:2], 2'b00};
                    cnt_r     <= len_s;
                    busy_r    <= 1'b1;
                    req_r     <= 1'b1;
                    state_r   <= ST_REQ;
                end
                ST_REQ: if (m_gnt) begin
                    addr_r  <= src_cur_r;
                    rstrb_r <= 1'b1;
                    state_r <= ST_RD;
                end
                ST_RD: if (m_gnt) begin
                    rstrb_r <= 1'b0;
                    state_r <= ST_RWAIT;
                end
                ST_RWAIT: if (m_gnt && !m_rbusy) begin
                    wdata_r <= m_rdata;
                    addr_r  <= dst_cur_r;
                    wmask_r <= 4'hF;
                    state_r <= ST_WR;
                end
                ST_WR: if (m_gnt && !m_wbusy) begin
                    wmask_r <= 4'h0;
                    state_r <= ST_NEXT;
                end
                ST_NEXT: if (m_gnt) begin
                    src_cur_r <= src_cur_r + WORD_STEP;
                    dst_cur_r <= dst_cur_r + WORD_STEP;
                    cnt_r     <= cnt_r - ONE_WORD;
                    if (cnt_r == ONE_WORD) begin
                        req_r   <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        addr_r  <= src_cur_r + WORD_STEP;
                        rstrb_r <= 1'b1;
                        state_r <= ST_RD;
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                default: begin
                    busy_r  <= 1'b0;
                    req_r   <= 1'b0;
                    rstrb_r <= 1'b0;
                    wmask_r <= 4'h0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_req   = req_r;
    assign m_addr  = addr_r;
    assign m_wdata = wdata_r;
    // Strobes never reach the bus without a grant
    assign m_rstrb = rstrb_r & m_gnt;
    assign m_wmask = wmask_r & {4{m_gnt}};

endmodule

// File: tb/tb_peripheral_dma.sv
// Directed scoreboard bench for peripheral_dma: a responder model feeds source
// words and logs committed writes, which are checked against expected copies.
`timescale 1ns/1ps
module tb_peripheral_dma;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] d_in = 32'h0;
    logic        cs = 1'b0;
    logic [4:0]  addr = 5'h0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] d_out;
    logic        m_req;
    logic        m_gnt = 1'b1;
    logic [31:0] m_addr;
    logic        m_rstrb;
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    logic        m_rbusy;
    logic        m_wbusy;
`ifdef DMA_IRQ_EN
    logic        irq;
`endif

    peripheral_dma #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .d_in    (d_in),
        .cs      (cs),
        .addr    (addr),
        .rd      (rd),
        .wr      (wr),
        .d_out   (d_out),
        .m_req   (m_req),
        .m_gnt   (m_gnt),
        .m_addr  (m_addr),
        .m_rstrb (m_rstrb),
        .m_rdata (m_rdata),
        .m_wdata (m_wdata),
        .m_wmask (m_wmask),
        .m_rbusy (m_rbusy),
        .m_wbusy (m_wbusy)
`ifdef DMA_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } xfer_t;

    xfer_t exp_q[$];
    xfer_t obs_q[$];

    int total = 0;
    int bad = 0;
    logic [31:0] seed = 32'h1234_5678;
    int rstall_word = -1;
    int rstall_n = 0;
    int wstall_word = -1;
    int wstall_n = 0;
    int read_count = 0;
    int write_count = 0;
    int rstall_cnt = 0;
    int wstall_cnt = 0;
    int ridx = 0;
    logic rpend = 1'b0;
    int gnt_viol = 0;
    int req_cycles = 0;
    int irq_rises = 0;

    function automatic logic [31:0] pat(input logic [31:0] a, input logic [31:0] s);
        return (a * 32'h9E37_79B1) ^ s;
    endfunction

    assign m_rbusy = rpend && (ridx == rstall_word) && (rstall_cnt < rstall_n);
    assign m_wbusy = (m_wmask != 4'h0) && (write_count == wstall_word) && (wstall_cnt < wstall_n);

    // Responder: source words come from pat(), committed writes are logged
    always @(posedge clk) begin
        if (m_rstrb && m_gnt) begin
            m_rdata    <= pat({m_addr[31:2], 2'b00}, seed);
            rpend      <= 1'b1;
            ridx       <= read_count;
            read_count <= read_count + 1;
            rstall_cnt <= 0;
        end else if (rpend) begin
            if (m_rbusy) rstall_cnt <= rstall_cnt + 1;
            else rpend <= 1'b0;
        end
        if ((m_wmask != 4'h0) && m_gnt) begin
            if (m_wbusy) begin
                wstall_cnt <= wstall_cnt + 1;
            end else begin
                obs_q.push_back('{m_addr, m_wdata, m_wmask});
                write_count <= write_count + 1;
                wstall_cnt  <= 0;
            end
        end
    end

    // Bus activity observer, sampled mid-cycle
    always @(negedge clk) begin
        if (!m_gnt && (m_rstrb || (m_wmask != 4'h0))) gnt_viol <= gnt_viol + 1;
        if (m_req) req_cycles <= req_cycles + 1;
    end

`ifdef DMA_IRQ_EN
    logic irq_prev = 1'b0;
    always @(negedge clk) begin
        irq_prev <= irq;
        if (irq && !irq_prev) irq_rises <= irq_rises + 1;
    end
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        d = d_out;
    endtask

    task automatic program_and_start(input logic [31:0] s, input logic [31:0] d, input int n);
        cpu_write(REG_SRC, s);
        cpu_write(REG_DST, d);
        cpu_write(REG_LEN, 32'(n));
        for (int i = 0; i < n; i++)
            exp_q.push_back('{d + 32'(4 * i), pat(s + 32'(4 * i), seed), 4'hF});
        cpu_write(REG_CTRL, 32'h1);
    endtask

    // Counts cycles from the first read strobe until m_req falls
    task automatic wait_done(input string tag, output int cyc);
        int n;
        n = 0;
        cyc = 0;
        while (!m_rstrb && n < 200) begin @(negedge clk); n++; end
        while (m_req && cyc < 2000) begin cyc++; @(negedge clk); end
        check({tag, "_finished"}, {31'h0, m_req}, 32'h0);
    endtask

    task automatic score(input string tag);
        xfer_t e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                check({tag, "_missing"}, 32'(exp_q.size() + 1), 32'h0);
                exp_q.delete();
                break;
            end
            o = obs_q.pop_front();
            check({tag, "_addr"}, o.a, e.a);
            check({tag, "_data"}, o.d, e.d);
            check({tag, "_mask"}, {28'h0, o.m}, {28'h0, e.m});
        end
        check({tag, "_extra"}, 32'(obs_q.size()), 32'h0);
        obs_q.delete();
    endtask

    initial begin
        logic [31:0] v;
        int cyc, rbase, wbase, qbase, gbase;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", {29'h0, m_req, m_rstrb, 1'b0}, 32'h0);
        check("rst_wmask", {28'h0, m_wmask}, 32'h0);
        check("rst_addr", m_addr, 32'h0);
        check("rst_wdata", m_wdata, 32'h0);
        check("rst_dout", d_out, 32'h0);
        resetn = 1'b1;
        cpu_read(REG_STATUS, v); check("rst_status", v, 32'h0);
        cpu_read(REG_SRC, v);    check("rst_src", v, 32'h0);

        // Plain 4-word copy, zero-wait responder
        rbase = read_count; wbase = write_count;
        program_and_start(32'h100, 32'h200, 4);
        wait_done("basic", cyc);
        check("basic_cycles", 32'(cyc), 32'd16);
        check("basic_reads", 32'(read_count - rbase), 32'd4);
        score("basic");
`ifdef DMA_IRQ_EN
        check("basic_irq_set", {31'h0, irq}, 32'h1);
`endif
        cpu_read(REG_STATUS, v); check("basic_status", v, 32'h2);
        cpu_read(REG_STATUS, v); check("basic_status_clr", v, 32'h0);
`ifdef DMA_IRQ_EN
        check("basic_irq_clr", {31'h0, irq}, 32'h0);
`endif
        cpu_read(REG_SRC, v); check("basic_src_kept", v, 32'h100);
        cpu_read(REG_LEN, v); check("basic_len_kept", v, 32'h4);
        cpu_read(5'h14, v);   check("unmapped_read", v, 32'h0);

        // Zero length: done without any bus traffic
        rbase = read_count; wbase = write_count; qbase = req_cycles;
        cpu_write(REG_LEN, 32'h0);
        cpu_write(REG_CTRL, 32'h1);
        repeat (5) @(negedge clk);
        check("len0_req", 32'(req_cycles - qbase), 32'h0);
        check("len0_traffic", 32'(read_count - rbase + write_count - wbase), 32'h0);
        cpu_read(REG_STATUS, v); check("len0_status", v, 32'h2);

        // Responder stalls: read stall on word 2, write stall on word 3
        seed = 32'hCAFE_0001;
        rbase = read_count;
        rstall_word = read_count + 1; rstall_n = 3;
        wstall_word = write_count + 2; wstall_n = 2;
        program_and_start(32'h300, 32'h400, 4);
        wait_done("stall", cyc);
        check("stall_cycles", 32'(cyc), 32'd21);
        check("stall_reads", 32'(read_count - rbase), 32'd4);
        score("stall");
        cpu_read(REG_STATUS, v); check("stall_status", v, 32'h2);
        rstall_word = -1; wstall_word = -1;

        // Grant withdrawn for 5 cycles while waiting on the first read
        seed = 32'h0BAD_F00D;
        rbase = read_count; gbase = gnt_viol;
        program_and_start(32'h500, 32'h600, 3);
        cyc = 0;
        while (!m_rstrb && cyc < 200) begin @(negedge clk); cyc++; end
        @(negedge clk);
        m_gnt = 1'b0;
        repeat (5) @(negedge clk);
        check("gnt_req_held", {31'h0, m_req}, 32'h1);
        m_gnt = 1'b1;
        cyc = 0;
        while (m_req && cyc < 2000) begin @(negedge clk); cyc++; end
        check("gnt_finished", {31'h0, m_req}, 32'h0);
        check("gnt_quiet", 32'(gnt_viol - gbase), 32'h0);
        check("gnt_reads", 32'(read_count - rbase), 32'd3);
        score("gnt");
        cpu_read(REG_STATUS, v); check("gnt_status", v, 32'h2);

        // Reprogramming while busy is ignored
        seed = 32'h5EED_7777;
        rbase = read_count;
        program_and_start(32'h700, 32'h800, 4);
        cpu_write(REG_SRC, 32'hDEAD);
        cpu_write(REG_CTRL, 32'h1);
        cpu_read(REG_SRC, v);    check("busy_src_kept", v, 32'h700);
        cpu_read(REG_STATUS, v); check("busy_status", v, 32'h1);
        cyc = 0;
        while (m_req && cyc < 2000) begin @(negedge clk); cyc++; end
        check("busy_finished", {31'h0, m_req}, 32'h0);
        check("busy_reads", 32'(read_count - rbase), 32'd4);
        score("busy");
        cpu_read(REG_STATUS, v); check("busy_done", v, 32'h2);

        // Reset asserted while the second word is being written
        seed = 32'h0000_00A5;
        wbase = write_count;
        program_and_start(32'h900, 32'hA00, 4);
        cyc = 0;
        while (!((m_wmask != 4'h0) && (write_count == wbase + 1)) && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check("abort_reach_wr2", {28'h0, m_wmask}, 32'hF);
        resetn = 1'b0;
        #1;
        check("abort_wmask", {28'h0, m_wmask}, 32'h0);
        check("abort_req", {30'h0, m_req, m_rstrb}, 32'h0);
        check("abort_addr", m_addr, 32'h0);
        repeat (3) @(negedge clk);
        check("abort_writes", 32'(write_count - wbase), 32'd1);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        score("abort");
        resetn = 1'b1;
        cpu_read(REG_STATUS, v); check("abort_status", v, 32'h0);
        cpu_read(REG_SRC, v);    check("abort_src", v, 32'h0);
`ifdef DMA_IRQ_EN
        check("irq_pulses", 32'(irq_rises), 32'd5);
        check("abort_irq", {31'h0, irq}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
